// File: rtl/word_array.sv
// Addressed WIDTH x DEPTH word storage with a valid/ready request port, 1-cycle read response
// and a zeroing sweep after reset or on clear_start. Optional write mask: WORD_ARRAY_WMASK_EN.
module word_array #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             op,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] in_bus,
`ifdef WORD_ARRAY_WMASK_EN
  input  logic [WIDTH-1:0] wmask,
`endif
  output logic             rsp_valid,
  output logic [WIDTH-1:0] out_bus,
  input  logic             clear_start,
  output logic             busy
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  logic [WIDTH-1:0] mem [DEPTH];

  state_e           state_q, state_d;
  logic [AW-1:0]    clr_ptr_q, clr_ptr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] out_bus_q, out_bus_d;

  logic             busy_c;
  logic             req_ready_c;
  logic             accept_c;
  logic             in_range_c;
  logic [WIDTH-1:0] rd_data_c;
  logic [WIDTH-1:0] wr_data_c;
  logic             mem_we_c;
  logic [AW-1:0]    mem_waddr_c;
  logic [WIDTH-1:0] mem_wdata_c;

  // Addresses past DEPTH-1 exist when DEPTH is not a power of two; they read as zero.
  assign in_range_c = ({1'b0, addr} < (AW+1)'(DEPTH));
  assign rd_data_c  = in_range_c ? mem[addr] : '0;

`ifdef WORD_ARRAY_WMASK_EN
  assign wr_data_c = (rd_data_c & ~wmask) | (in_bus & wmask);
`else
  assign wr_data_c = in_bus;
`endif

  // Next-state, storage write port and response logic
  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    rsp_valid_d = 1'b0;
    out_bus_d   = out_bus_q;
    busy_c      = 1'b0;
    req_ready_c = 1'b0;
    accept_c    = 1'b0;
    mem_we_c    = 1'b0;
    mem_waddr_c = clr_ptr_q;
    mem_wdata_c = '0;

    case (state_q)
      ST_CLEAR: begin
        busy_c   = 1'b1;
        mem_we_c = 1'b1;
        if (clr_ptr_q == AW'(DEPTH - 1)) begin
          state_d   = ST_IDLE;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + AW'(1);
        end
      end
      ST_IDLE: begin
        req_ready_c = ~clear_start;
        accept_c    = req_valid & req_ready_c;
        if (clear_start) begin
          state_d = ST_CLEAR;
        end
        if (accept_c && op) begin
          mem_we_c    = in_range_c;
          mem_waddr_c = addr;
          mem_wdata_c = wr_data_c;
        end
        if (accept_c && !op) begin
          rsp_valid_d = 1'b1;
          out_bus_d   = rd_data_c;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      clr_ptr_q   <= '0;
      rsp_valid_q <= 1'b0;
      out_bus_q   <= '0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      out_bus_q   <= out_bus_d;
    end
  end

  // Storage is not reset; the sweep zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[mem_waddr_c] <= mem_wdata_c;
    end
  end

  assign busy      = busy_c;
  assign req_ready = req_ready_c;
  assign rsp_valid = rsp_valid_q;
  assign out_bus   = out_bus_q;

endmodule
